round_key_add: RTL

ROUND_KEY_ADD -- requirements
Module: round_key_add

---
 rtl/aes_pkg.sv | 32 +++
 rtl/aes_sbox.sv | 59 +++++
 rtl/round_key_add.sv | 102 ++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared AES-128 constants: widths, round count and the Rcon
//                table used by the on-the-fly key schedule.
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

   localparam int STATE_W    = 128;
   localparam int WORD_W     = 32;
   localparam int ROUND_W    = 4;
   localparam int AES_ROUNDS = 10;

   // Round constants for rounds 1..10; entry i serves round i+1.
   localparam logic [7:0] RCON [AES_ROUNDS] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
      8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   // Rcon byte needed to step from round r to round r+1 (zero past the end).
   function automatic logic [7:0] rcon_next(input logic [ROUND_W-1:0] r);
      logic [7:0] rc;
      rc = 8'h00;
      if (r < ROUND_W'(AES_ROUNDS)) begin
         rc = RCON[r];
      end
      return rc;
   endfunction

endpackage : aes_pkg
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
//  Module      : aes_sbox
//  Description : Combinational AES S-box. Computes the GF(2^8) multiplicative
//                inverse (x^254) followed by the AES affine transform, so no
//                256-entry table has to be maintained by hand.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_sbox (
   input  logic [7:0] data,
   output logic [7:0] subst
);

   // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] sh;
      acc = 8'h00;
      sh  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) begin
            acc = acc ^ sh;
         end
         sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
      end
      return acc;
   endfunction

   logic [7:0] inv;

   // Inverse by square-and-multiply for exponent 254; 0 maps to 0 naturally.
   always_comb begin
      logic [7:0] base;
      logic [7:0] res;
      logic [7:0] expo;
      base = data;
      res  = 8'h01;
      expo = 8'd254;
      for (int i = 0; i < 8; i++) begin
         if (expo[i]) begin
            res = gf_mul(res, base);
         end
         base = gf_mul(base, base);
      end
      inv = res;
   end

   // Affine transform: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
   always_comb begin
      subst = inv
            ^ {inv[6:0], inv[7]}
            ^ {inv[5:0], inv[7:6]}
            ^ {inv[4:0], inv[7:5]}
            ^ {inv[3:0], inv[7:4]}
            ^ 8'h63;
   end

endmodule : aes_sbox
`default_nettype wire

// File: rtl/round_key_add.sv
`default_nettype none
// ============================================================================
//  Module      : round_key_add
//  Description : AES-128 AddRoundKey stage with an on-the-fly key schedule.
//                Each accepted state is XORed with the current round key and
//                registered; the schedule then steps to the next round key,
//                wrapping back to the stored cipher key after round 10.
//  Revision    : 1.0 - initial release
// ============================================================================
module round_key_add
   import aes_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               key_load,
   input  logic [STATE_W-1:0] key_in,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [STATE_W-1:0] state_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [STATE_W-1:0] state_out,
   output logic [ROUND_W-1:0] round_out
);

   logic [STATE_W-1:0] cipher_key;
   logic [STATE_W-1:0] round_key;
   logic [ROUND_W-1:0] round_cnt;
   logic               key_loaded;

   logic               accept;
   logic               last_round;
   logic [WORD_W-1:0]  w0, w1, w2, w3;
   logic [WORD_W-1:0]  rot_w3;
   logic [WORD_W-1:0]  sub_w;
   logic [WORD_W-1:0]  w4, w5, w6, w7;
   logic [STATE_W-1:0] next_round_key;

   // A key load steals the cycle so the schedule restart is never mixed with a transfer.
   assign in_ready   = key_loaded && !key_load && (!out_valid || out_ready);
   assign accept     = in_valid && in_ready;
   assign last_round = (round_cnt == ROUND_W'(AES_ROUNDS));

   // Next schedule word set, derived combinationally from the current round key.
   assign {w0, w1, w2, w3} = round_key;
   assign rot_w3 = {w3[23:0], w3[31:24]};

   generate
      for (genvar g = 0; g < 4; g++) begin : g_sbox
         aes_sbox u_sbox (
            .data  (rot_w3[g*8 +: 8]),
            .subst (sub_w[g*8 +: 8])
         );
      end
   endgenerate

   assign w4 = w0 ^ sub_w ^ {rcon_next(round_cnt), 24'h000000};
   assign w5 = w1 ^ w4;
   assign w6 = w2 ^ w5;
   assign w7 = w3 ^ w6;
   assign next_round_key = {w4, w5, w6, w7};

   // Key copy, round key and round counter; key_load restarts the schedule.
   always_ff @(posedge clk) begin
      if (reset) begin
         cipher_key <= '0;
         round_key  <= '0;
         round_cnt  <= '0;
         key_loaded <= 1'b0;
      end else if (key_load) begin
         cipher_key <= key_in;
         round_key  <= key_in;
         round_cnt  <= '0;
         key_loaded <= 1'b1;
      end else if (accept) begin
         if (last_round) begin
            round_cnt <= '0;
            round_key <= cipher_key;
         end else begin
            round_cnt <= round_cnt + 1'b1;
            round_key <= next_round_key;
         end
      end
   end

   // Output register: load on transfer, hold under backpressure, retire on ready.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         state_out <= '0;
         round_out <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         state_out <= state_in ^ round_key;
         round_out <= round_cnt;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule : round_key_add
`default_nettype wire
